// File: rtl/compress_line_scheduler.sv
// Line sequencer for the compression datapath: feeds word pairs, tracks compressed-bit
// occupancy, emits 128-bit beats and a padded flush beat. Define COMPRESS_ABORT_EN for the incompressible-line abort.
module compress_line_scheduler #(
    parameter int CACHE_LINE = 128,
    parameter int WORD_SIZE  = 64,
    parameter int MAX_PAIRS  = 8,
    parameter int PW         = $clog2(MAX_PAIRS),
    parameter int LW         = PW + 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic [PW:0]   i_num_pairs,
    output logic          o_pair_valid,
    output logic [PW-1:0] o_pair_idx,
    input  logic [6:0]    i_total_length,
    output logic          o_beat_valid,
    input  logic          i_beat_ready,
    output logic          o_fill,
    output logic [7:0]    o_fill_bits,
    output logic          o_done,
    output logic [LW-1:0] o_line_bits,
    output logic [PW+1:0] o_beat_count,
    output logic          o_bypass
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        EMIT  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int         NW        = PW + 1;
    localparam int         AW        = LW + 1;
    localparam logic [8:0] BEAT_BITS = 9'(CACHE_LINE);
    localparam logic [PW:0] MAX_N    = NW'(MAX_PAIRS);

    if (2 * WORD_SIZE != CACHE_LINE) begin : g_geometry_mismatch
        $error("compress_line_scheduler: a word pair must span exactly one beat");
    end

    state_t        state, state_d;
    logic [7:0]    acc, acc_d;
    logic [PW:0]   pair_cnt, pair_cnt_d;
    logic [PW:0]   num, num_d;
    logic [LW-1:0] line_bits, line_bits_d;
    logic [PW+1:0] beat_cnt, beat_cnt_d;

    logic [8:0]    sum;
    logic [LW-1:0] line_sum;
    logic [PW:0]   pair_nxt;
    logic          last_pair;
    logic          abort;

    // acc stays below one beat, so a single pair can cross at most one boundary
    assign sum       = {1'b0, acc} + {2'b00, i_total_length};
    assign line_sum  = line_bits + LW'(i_total_length);
    assign pair_nxt  = pair_cnt + 1'b1;
    assign last_pair = (pair_nxt == num);

`ifdef COMPRESS_ABORT_EN
    logic [AW-1:0] raw_limit;

    assign raw_limit = AW'(num) * AW'(CACHE_LINE);
    assign abort     = ({1'b0, line_sum} > raw_limit);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_bypass <= 1'b0;
        end else if (state == IDLE && i_req_valid) begin
            o_bypass <= 1'b0;
        end else if (state == FEED && abort) begin
            o_bypass <= 1'b1;
        end
    end
`else
    assign abort    = 1'b0;
    assign o_bypass = 1'b0;
`endif

    always_comb begin
        state_d     = state;
        acc_d       = acc;
        pair_cnt_d  = pair_cnt;
        num_d       = num;
        line_bits_d = line_bits;
        beat_cnt_d  = beat_cnt;
        case (state)
            IDLE: begin
                if (i_req_valid) begin
                    num_d       = (i_num_pairs == '0 || i_num_pairs > MAX_N) ? MAX_N : i_num_pairs;
                    acc_d       = '0;
                    pair_cnt_d  = '0;
                    line_bits_d = '0;
                    beat_cnt_d  = '0;
                    state_d     = FEED;
                end
            end
            FEED: begin
                pair_cnt_d  = pair_nxt;
                line_bits_d = line_sum;
                if (abort) begin
                    state_d = DONE;
                end else if (sum >= BEAT_BITS) begin
                    acc_d   = 8'(sum - BEAT_BITS);
                    state_d = EMIT;
                end else begin
                    acc_d = sum[7:0];
                    if (last_pair) begin
                        state_d = (sum != '0) ? FLUSH : DONE;
                    end
                end
            end
            EMIT: begin
                if (i_beat_ready) begin
                    beat_cnt_d = beat_cnt + 1'b1;
                    if (pair_cnt < num) begin
                        state_d = FEED;
                    end else if (acc != '0) begin
                        state_d = FLUSH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FLUSH: begin
                if (i_beat_ready) begin
                    beat_cnt_d = beat_cnt + 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered decodes of the next state so they line up with the state register
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state        <= IDLE;
            acc          <= '0;
            pair_cnt     <= '0;
            num          <= '0;
            line_bits    <= '0;
            beat_cnt     <= '0;
            o_req_ready  <= 1'b1;
            o_pair_valid <= 1'b0;
            o_beat_valid <= 1'b0;
            o_fill       <= 1'b0;
            o_fill_bits  <= '0;
            o_done       <= 1'b0;
        end else begin
            state        <= state_d;
            acc          <= acc_d;
            pair_cnt     <= pair_cnt_d;
            num          <= num_d;
            line_bits    <= line_bits_d;
            beat_cnt     <= beat_cnt_d;
            o_req_ready  <= (state_d == IDLE);
            o_pair_valid <= (state_d == FEED);
            o_beat_valid <= (state_d == EMIT) || (state_d == FLUSH);
            o_fill       <= (state_d == FLUSH);
            o_fill_bits  <= (state_d == FLUSH) ? 8'(BEAT_BITS - {1'b0, acc_d}) : 8'd0;
            o_done       <= (state_d == DONE);
        end
    end

    assign o_pair_idx   = pair_cnt[PW-1:0];
    assign o_line_bits  = line_bits;
    assign o_beat_count = beat_cnt;

endmodule

// File: tb/tb_compress_line_scheduler.sv
// Self-checking bench for compress_line_scheduler: randomized lines checked against a
// prefix-sum model of beat crossings, flush padding and line totals.
module tb_compress_line_scheduler;

    localparam int PW = 3;
    localparam int LW = 11;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_req_valid;
    logic          o_req_ready;
    logic [PW:0]   i_num_pairs;
    logic          o_pair_valid;
    logic [PW-1:0] o_pair_idx;
    logic [6:0]    i_total_length;
    logic          o_beat_valid;
    logic          i_beat_ready;
    logic          o_fill;
    logic [7:0]    o_fill_bits;
    logic          o_done;
    logic [LW-1:0] o_line_bits;
    logic [PW+1:0] o_beat_count;
    logic          o_bypass;

    int checks = 0;
    int errors = 0;
    int lens[8];
    int last_beat_cycles = 0;

    always #5 clk = ~clk;

    compress_line_scheduler dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_num_pairs    (i_num_pairs),
        .o_pair_valid   (o_pair_valid),
        .o_pair_idx     (o_pair_idx),
        .i_total_length (i_total_length),
        .o_beat_valid   (o_beat_valid),
        .i_beat_ready   (i_beat_ready),
        .o_fill         (o_fill),
        .o_fill_bits    (o_fill_bits),
        .o_done         (o_done),
        .o_line_bits    (o_line_bits),
        .o_beat_count   (o_beat_count),
        .o_bypass       (o_bypass)
    );

    task automatic test_reset();
        i_reset        = 1'b0;
        i_req_valid    = 1'b0;
        i_num_pairs    = '0;
        i_total_length = '0;
        i_beat_ready   = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (o_req_ready !== 1'b1 || o_pair_valid !== 1'b0 || o_beat_valid !== 1'b0 || o_fill !== 1'b0 ||
            o_fill_bits !== 8'd0 || o_done !== 1'b0 || o_pair_idx !== '0 || o_line_bits !== '0 ||
            o_beat_count !== '0 || o_bypass !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b pv=%b bv=%b fill=%b fb=%0d done=%b idx=%0d lb=%0d bc=%0d byp=%b, required ready=1 others 0",
                     o_req_ready, o_pair_valid, o_beat_valid, o_fill, o_fill_bits, o_done, o_pair_idx,
                     o_line_bits, o_beat_count, o_bypass);
        end
        i_reset = 1'b1;
        @(negedge clk);
    endtask

    // Event codes: pair index k, 1000 = full beat, 2000+pad = flush beat.
    // stall_mode: 0 ready always, 1 random ready, 2 ready low for the first 3 cycles of each beat.
    task automatic run_line(input string name, input int num_in, input int stall_mode);
        int n, total, prev, exp_beats, cyc, bcycles, first_bad;
        int exp_ev[$];
        int act_ev[$];
        bit done_seen, stalled;
        logic pf;
        logic [7:0] pfb;

        n = (num_in == 0 || num_in > 8) ? 8 : num_in;
        total = 0;
        for (int k = 0; k < n; k++) begin
            prev = total;
            total += lens[k];
            exp_ev.push_back(k);
            if (total / 128 != prev / 128) exp_ev.push_back(1000);
        end
        if (total % 128 != 0) exp_ev.push_back(2000 + 128 - total % 128);
        exp_beats = total / 128 + ((total % 128 != 0) ? 1 : 0);

        i_num_pairs = 4'(num_in);
        i_req_valid = 1'b1;
        checks++;
        if (o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: got %b required 1", name, o_req_ready);
        end
        @(negedge clk);
        i_req_valid = 1'b0;
        checks++;
        if (o_pair_valid !== 1'b1 || o_pair_idx !== '0) begin
            errors++;
            $display("FAIL %s_first_pair: pair_valid=%b idx=%0d required 1 and 0", name, o_pair_valid, o_pair_idx);
        end

        stalled   = 1'b0;
        done_seen = 1'b0;
        bcycles   = 0;
        cyc       = 0;
        pf        = 1'b0;
        pfb       = '0;
        while (cyc < 400 && !done_seen) begin
            if (stalled) begin
                checks++;
                if (o_beat_valid !== 1'b1 || o_fill !== pf || o_fill_bits !== pfb) begin
                    errors++;
                    $display("FAIL %s_beat_hold: valid=%b fill=%b fb=%0d required 1 %b %0d",
                             name, o_beat_valid, o_fill, o_fill_bits, pf, pfb);
                end
            end
            if (o_done === 1'b1) begin
                done_seen = 1'b1;
            end else begin
                i_total_length = 7'($urandom);
                i_beat_ready   = 1'($urandom);
                stalled        = 1'b0;
                if (o_pair_valid === 1'b1) begin
                    act_ev.push_back(int'(o_pair_idx));
                    i_total_length = 7'(lens[o_pair_idx]);
                end
                if (o_beat_valid === 1'b1) begin
                    bcycles++;
                    case (stall_mode)
                        0:       i_beat_ready = 1'b1;
                        2:       i_beat_ready = (bcycles > 3);
                        default: i_beat_ready = 1'($urandom);
                    endcase
                    if (i_beat_ready) begin
                        act_ev.push_back(o_fill ? 2000 + int'(o_fill_bits) : 1000);
                        last_beat_cycles = bcycles;
                        bcycles = 0;
                    end else begin
                        stalled = 1'b1;
                        pf      = o_fill;
                        pfb     = o_fill_bits;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end

        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL %s_done_timeout: no done within %0d cycles", name, cyc);
        end else begin
            checks++;
            if (o_line_bits !== LW'(total)) begin
                errors++;
                $display("FAIL %s_line_bits: got %0d required %0d", name, o_line_bits, total);
            end
            checks++;
            if (o_beat_count !== 5'(exp_beats)) begin
                errors++;
                $display("FAIL %s_beat_count: got %0d required %0d", name, o_beat_count, exp_beats);
            end
            checks++;
            if (o_bypass !== 1'b0) begin
                errors++;
                $display("FAIL %s_bypass: got %b required 0", name, o_bypass);
            end
            first_bad = -1;
            for (int i = 0; i < exp_ev.size(); i++) begin
                if (first_bad < 0 && (i >= act_ev.size() || act_ev[i] != exp_ev[i])) first_bad = i;
            end
            if (first_bad < 0 && act_ev.size() != exp_ev.size()) first_bad = exp_ev.size();
            checks++;
            if (first_bad >= 0) begin
                errors++;
                $display("FAIL %s_sequence: event %0d got %0d required %0d (got %0d events, required %0d)",
                         name, first_bad, (first_bad < act_ev.size()) ? act_ev[first_bad] : -1,
                         (first_bad < exp_ev.size()) ? exp_ev[first_bad] : -1, act_ev.size(), exp_ev.size());
            end
        end
        i_beat_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_after_done: done=%b ready=%b required 0 and 1", name, o_done, o_req_ready);
        end
    endtask

    task automatic test_flush_two_pairs();
        lens[0] = 40;
        lens[1] = 50;
        run_line("flush_40_50", 2, 0);
    endtask

    task automatic test_multi_emit();
        for (int k = 0; k < 4; k++) lens[k] = 100;
        run_line("emit_4x100", 4, 1);
    endtask

    task automatic test_exact_stall();
        lens[0] = 64;
        lens[1] = 64;
        run_line("exact_64_64", 2, 2);
        checks++;
        if (last_beat_cycles != 4) begin
            errors++;
            $display("FAIL exact_stall_cycles: beat_valid cycles got %0d required 4", last_beat_cycles);
        end
    endtask

    task automatic test_pair_count_saturation();
        for (int k = 0; k < 8; k++) lens[k] = int'($urandom_range(0, 127));
        run_line("num_zero", 0, 1);
        for (int k = 0; k < 8; k++) lens[k] = int'($urandom_range(0, 127));
        run_line("num_13", 13, 1);
        for (int k = 0; k < 8; k++) lens[k] = 127;
        run_line("max_127", 8, 0);
        for (int k = 0; k < 8; k++) lens[k] = 0;
        run_line("all_zero", 3, 0);
    endtask

    task automatic test_reset_midline();
        int cyc, done_cnt;
        bit seen;
        for (int k = 0; k < 8; k++) lens[k] = 10;
        i_num_pairs = '0;
        i_req_valid = 1'b1;
        @(negedge clk);
        i_req_valid = 1'b0;
        seen = 1'b0;
        cyc  = 0;
        while (cyc < 20 && !seen) begin
            i_total_length = 7'd10;
            if (o_pair_valid === 1'b1 && o_pair_idx === 3'd4) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midreset_reach_pair4: got idx %0d required 4", o_pair_idx);
        end
        i_reset = 1'b0;
        @(negedge clk);
        checks++;
        if (o_req_ready !== 1'b1 || o_pair_valid !== 1'b0 || o_done !== 1'b0 || o_beat_valid !== 1'b0 ||
            o_pair_idx !== '0) begin
            errors++;
            $display("FAIL midreset_idle: ready=%b pv=%b done=%b bv=%b idx=%0d required 1 0 0 0 0",
                     o_req_ready, o_pair_valid, o_done, o_beat_valid, o_pair_idx);
        end
        i_reset  = 1'b1;
        done_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (o_done === 1'b1 || o_pair_valid === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt != 0 || o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_quiet: done/pair cycles got %0d required 0, ready=%b", done_cnt, o_req_ready);
        end
    endtask

    task automatic test_random_lines();
        int num_in;
        for (int t = 0; t < 25; t++) begin
            num_in = int'($urandom_range(0, 15));
            for (int k = 0; k < 8; k++) begin
                case ($urandom_range(0, 3))
                    0:       lens[k] = 127;
                    1:       lens[k] = 0;
                    default: lens[k] = int'($urandom_range(0, 127));
                endcase
            end
            run_line("random", num_in, int'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_flush_two_pairs();
        test_multi_emit();
        test_exact_stall();
        test_pair_count_saturation();
        test_reset_midline();
        test_random_lines();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
